huffman_param: RTL and testbench
================================

# huffman_param

Parametrised Huffman code generator for the grey-level statistics path. It counts occurrences of symbols 1..NSYM in a `gray_data` stream, then reports the per-symbol counts. It then builds a Huffman code over the non-zero symbols with a fully defined tie-break rule and reports the per-symbol codewords and length masks. This block succeeds the fixed 6-symbol encoder and adds the following:
- any symbol count
- count saturation
- exclusion of zero-count symbols
- a single-symbol case
- a `busy` indication

## Interface
Parameters:
- `NSYM`, 6: number of symbols, range 2..16; symbol k is `gray_data` value k (1..NSYM).
- `CNT_W`, 8: width of each occurrence counter.
- `CODE_W`, 8: width of each codeword/mask field; must be ≥ NSYM-1 (elaboration error otherwise).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `gray_valid`  in  1  `gray_data` is a sample this cycle.
- `gray_data`  in  8  sample value; values 0 and >NSYM are ignored (not counted).
- `busy`  out  1  high from frame end until the `code_valid` cycle inclusive; samples are ignored while high.
- `CNT_valid`  out  1  one-cycle pulse; `CNT` is final.
- `CNT`  out  NSYM*CNT_W  packed counts, symbol k at bits [k*CNT_W-1 -: CNT_W].
- `code_valid`  out  1  one-cycle pulse; `HC`/`M` are final.
- `HC`  out  NSYM*CODE_W  packed codewords, right-aligned, first tree bit (root) at the MSB of the used length.
- `M`  out  NSYM*CODE_W  packed masks, with L low-order ones for code length L; 0 for unused symbols.

## Operation
- States: IDLE → CNT_OUT → SORT → MERGE → DONE → IDLE.
- IDLE: each valid in-range sample increments its counter. The counter saturates at 2^CNT_W-1 and does not wrap.
- Frame start: the first counted or ignored valid sample in IDLE after a completed frame synchronously clears `CNT`, `HC` and `M`, and that sample is counted in the same cycle.
- Frame end: `gray_valid` is low in IDLE and at least one valid sample has arrived since frame start. The block moves to CNT_OUT, and `busy` rises.
- CNT_OUT: `CNT_valid` pulses for one cycle. `CNT` is held stable from here until the next frame start.
- SORT: build an ordered node list from the symbols with count > 0. Each node holds a weight of width CNT_W+clog2(NSYM) and a membership mask.
  - Ascending order by weight.
  - Leaf ties: the higher symbol index ranks smaller.
- MERGE, repeated until one node remains:
  - Take the two smallest nodes. Every member of the smallest gets bit 1; every member of the second gets bit 0. These bits are prepended at the MSB side and the member's length is incremented by 1.
  - Replace the two with one node: weight = sum, mask = OR of the two masks.
  - Insert the new node before all existing nodes of equal weight.
- Single non-zero symbol: its code is 1'b0 and its mask is 1. SORT/MERGE take no merge steps.
- DONE: `code_valid` pulses for one cycle, and `busy` falls on the next cycle. Symbols with zero count get HC=0 and M=0.
- Reset at any point, including mid-MERGE: every output is 0 on the next edge and the state is IDLE. No partial `code_valid` is produced.

## Timing
- Reset values: `busy`=0, `CNT_valid`=0, `code_valid`=0, `CNT`=0, `HC`=0, `M`=0.
- Counters update on the cycle after the sample edge.
- `CNT_valid` is asserted 2 cycles after the first low-`gray_valid` cycle.
- `code_valid` is asserted within 2*NSYM*NSYM+8 cycles after `CNT_valid`.
- The latency for a given NSYM and a given set of non-zero symbols is deterministic.
- `CNT_valid` and `code_valid` are never high in the same cycle.
- Simultaneous `gray_valid` and `busy`: the sample is dropped and counters are unchanged.
- `HC` and `M` hold after `code_valid` until the next frame start.

## Test plan
- NSYM=6, samples in order 1,1,1,1,2,2,3,4:
  - Expected `CNT` = 4,2,1,1,0,0.
  - Expected `HC` = 0,2,6,7,0,0.
  - Expected `M` = 1,3,7,7,0,0.
  - Expected `code_valid` pulses exactly once.
- NSYM=6, one sample each of 1..6:
  - Expected `HC` = 2,3,0,1,2,3.
  - Expected `M` = 7,7,7,7,3,3.
- NSYM=6, five samples of 3 interleaved with values 0, 7 and 200:
  - Expected `CNT3`=5 and all other counts 0.
  - Expected HC3=0 and M3=1; all other fields 0.
- Saturation: CNT_W=8, 300 samples of 1, then 1 sample of 2:
  - Expected CNT1=255 and CNT2=1.
  - Expected HC1=0 with M1=1, and HC2=1 with M2=1.
- Busy and reset:
  - Samples with `gray_valid` high during `busy` leave `CNT` unchanged.
  - Asserting `reset` during MERGE clears all outputs to 0, and no `code_valid` follows.
  - A fresh frame after that reset produces the correct codes.
- NSYM=16, one sample each of 1..16: every M field is 4'hF, and all 16 codes are distinct.

Source files
------------

// File: rtl/huffman_param.sv
// Symbol histogram and Huffman code builder for the grey-level stats path.
// Counts a frame of samples, then sorts and merges one node per cycle.
module huffman_param #(
    parameter int NSYM   = 6,
    parameter int CNT_W  = 8,
    parameter int CODE_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     gray_valid,
    input  logic [7:0]               gray_data,
    output logic                     busy,
    output logic                     CNT_valid,
    output logic [NSYM*CNT_W-1:0]    CNT,
    output logic                     code_valid,
    output logic [NSYM*CODE_W-1:0]   HC,
    output logic [NSYM*CODE_W-1:0]   M
);

    localparam int WW = CNT_W + $clog2(NSYM);
    localparam int NW = $clog2(NSYM + 1);
    localparam int IW = $clog2(NSYM);

    if (NSYM < 2 || NSYM > 16) begin : g_bad_nsym
        $error("huffman_param: NSYM must be 2..16");
    end
    if (CODE_W < NSYM - 1) begin : g_bad_code_w
        $error("huffman_param: CODE_W must be >= NSYM-1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_OUT,
        S_SORT,
        S_MERGE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt  [NSYM];
    logic [CODE_W-1:0] r_hc   [NSYM];
    logic [CODE_W-1:0] r_m    [NSYM];
    logic [WW-1:0]     r_w    [NSYM];
    logic [NSYM-1:0]   r_mask [NSYM];
    logic [NW-1:0]     r_n;
    logic              r_seen;
    logic              r_cnt_valid;
    logic              r_code_valid;

    logic              w_busy;
    logic              w_take;
    logic              w_end;
    logic [CNT_W-1:0]  w_cnt_nxt [NSYM];
    logic [IW-1:0]     w_rank    [NSYM];
    logic [NW-1:0]     w_nnz;
    logic [WW-1:0]     w_sum;
    logic [NW-1:0]     w_pos;
    logic [WW-1:0]     w_lw [NSYM];
    logic [NSYM-1:0]   w_lm [NSYM];

    function automatic int clip(input int idx);
        return (idx < NSYM) ? idx : NSYM - 1;
    endfunction

    // busy spans the registered code_valid cycle as well
    assign w_busy = (r_state != S_IDLE) || r_code_valid;
    assign w_take = gray_valid && !w_busy;
    assign w_end  = !w_busy && !gray_valid && r_seen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_end) w_next = S_CNT_OUT;
            S_CNT_OUT: w_next = S_SORT;
            S_SORT:    w_next = S_MERGE;
            S_MERGE:   if (r_n <= NW'(1)) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // first sample of a frame restarts the counters from zero
    always_comb begin
        for (int k = 0; k < NSYM; k++) begin
            w_cnt_nxt[k] = r_seen ? r_cnt[k] : '0;
            if (gray_data == 8'(k + 1) && w_cnt_nxt[k] != '1)
                w_cnt_nxt[k] = w_cnt_nxt[k] + CNT_W'(1);
        end
    end

    // leaf rank: ascending count, higher symbol first on ties
    always_comb begin
        w_nnz = '0;
        for (int i = 0; i < NSYM; i++) begin
            w_rank[i] = '0;
            if (r_cnt[i] != '0) w_nnz = w_nnz + NW'(1);
            for (int j = 0; j < NSYM; j++) begin
                if (r_cnt[j] != '0 &&
                    (r_cnt[j] < r_cnt[i] ||
                     (r_cnt[j] == r_cnt[i] && j > i)))
                    w_rank[i] = w_rank[i] + IW'(1);
            end
        end
    end

    // merged node goes ahead of every equal-weight survivor
    always_comb begin
        w_sum = r_w[0] + r_w[1];
        w_pos = '0;
        for (int j = 2; j < NSYM; j++) begin
            if (NW'(j) < r_n && r_w[j] < w_sum)
                w_pos = w_pos + NW'(1);
        end
        for (int i = 0; i < NSYM; i++) begin
            if (NW'(i) < w_pos) begin
                w_lw[i] = r_w[clip(i + 2)];
                w_lm[i] = r_mask[clip(i + 2)];
            end else if (NW'(i) == w_pos) begin
                w_lw[i] = w_sum;
                w_lm[i] = r_mask[0] | r_mask[1];
            end else begin
                w_lw[i] = r_w[clip(i + 1)];
                w_lm[i] = r_mask[clip(i + 1)];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSYM; k++) begin
                r_cnt[k]  <= '0;
                r_hc[k]   <= '0;
                r_m[k]    <= '0;
                r_w[k]    <= '0;
                r_mask[k] <= '0;
            end
            r_n          <= '0;
            r_seen       <= 1'b0;
            r_cnt_valid  <= 1'b0;
            r_code_valid <= 1'b0;
        end else begin
            r_cnt_valid  <= (r_state == S_CNT_OUT);
            r_code_valid <= (r_state == S_DONE);
            if (w_take) begin
                r_seen <= 1'b1;
                for (int k = 0; k < NSYM; k++) begin
                    r_cnt[k] <= w_cnt_nxt[k];
                    if (!r_seen) begin
                        r_hc[k] <= '0;
                        r_m[k]  <= '0;
                    end
                end
            end
            if (w_end) r_seen <= 1'b0;
            if (r_state == S_SORT) begin
                r_n <= w_nnz;
                for (int i = 0; i < NSYM; i++) begin
                    if (r_cnt[i] != '0) begin
                        r_w[w_rank[i]]    <= WW'(r_cnt[i]);
                        r_mask[w_rank[i]] <= NSYM'(1) << i;
                        if (w_nnz == NW'(1)) r_m[i] <= CODE_W'(1);
                    end
                end
            end
            if (r_state == S_MERGE && r_n > NW'(1)) begin
                r_n <= r_n - NW'(1);
                for (int i = 0; i < NSYM; i++) begin
                    r_w[i]    <= w_lw[i];
                    r_mask[i] <= w_lm[i];
                end
                // new bit lands just above the current length: m+1
                for (int k = 0; k < NSYM; k++) begin
                    if (r_mask[0][k]) begin
                        r_hc[k] <= r_hc[k] | (r_m[k] + CODE_W'(1));
                        r_m[k]  <= (r_m[k] << 1) | CODE_W'(1);
                    end else if (r_mask[1][k]) begin
                        r_m[k]  <= (r_m[k] << 1) | CODE_W'(1);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NSYM; g++) begin : g_pack
        assign CNT[g*CNT_W +: CNT_W]  = r_cnt[g];
        assign HC[g*CODE_W +: CODE_W] = r_hc[g];
        assign M[g*CODE_W +: CODE_W]  = r_m[g];
    end

    assign busy       = w_busy;
    assign CNT_valid  = r_cnt_valid;
    assign code_valid = r_code_valid;

endmodule

// File: tb/tb_huffman_param.sv
// Directed bench for huffman_param: a 6-symbol and a 16-symbol instance.
module tb_huffman_param;

    logic         clk = 1'b0;
    logic         rst;
    logic         gv6;
    logic [7:0]   gd6;
    logic         busy6, cntv6, codev6;
    logic [47:0]  cnt6, hc6, m6;
    logic         gv16;
    logic [7:0]   gd16;
    logic         busy16, cntv16, codev16;
    logic [127:0] cnt16;
    logic [255:0] hc16, m16;

    int n_total = 0;
    int n_bad   = 0;
    int e_cnt[6];
    int e_hc[6];
    int e_m[6];

    always #5 clk = ~clk;

    huffman_param #(.NSYM(6), .CNT_W(8), .CODE_W(8)) u_dut6 (
        .clk(clk), .reset(rst), .gray_valid(gv6), .gray_data(gd6),
        .busy(busy6), .CNT_valid(cntv6), .CNT(cnt6),
        .code_valid(codev6), .HC(hc6), .M(m6)
    );

    huffman_param #(.NSYM(16), .CNT_W(8), .CODE_W(16)) u_dut16 (
        .clk(clk), .reset(rst), .gray_valid(gv16), .gray_data(gd16),
        .busy(busy16), .CNT_valid(cntv16), .CNT(cnt16),
        .code_valid(codev16), .HC(hc16), .M(m16)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send6(input int v);
        @(negedge clk);
        gv6 = 1'b1;
        gd6 = 8'(v);
    endtask

    task automatic wait_cntv6(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cntv6) break;
        end
        chk({tag, "_cntv_seen"}, cntv6, 1);
    endtask

    task automatic wait_codev6(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (codev6) break;
        end
        chk({tag, "_codev_seen"}, codev6, 1);
    endtask

    task automatic close6(input string tag);
        int ncv, nov, first;
        bit prev;
        @(negedge clk);
        gv6 = 1'b0;
        gd6 = 8'd0;
        @(negedge clk);
        chk({tag, "_busy_rise"}, busy6, 1);
        chk({tag, "_cntv_early"}, cntv6, 0);
        @(negedge clk);
        chk({tag, "_cntv"}, cntv6, 1);
        ncv = 0; nov = 0; first = -1; prev = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (prev) chk({tag, "_busy_fall"}, busy6, 0);
            if (cntv6 && codev6) nov++;
            if (codev6) begin
                ncv++;
                if (first < 0) first = i;
                chk({tag, "_busy_at_cv"}, busy6, 1);
            end
            prev = codev6;
            @(negedge clk);
        end
        chk({tag, "_cv_pulses"}, ncv, 1);
        chk({tag, "_cv_latency"}, (first > 0 && first <= 80), 1);
        chk({tag, "_overlap"}, nov, 0);
    endtask

    task automatic chk6(input string tag);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("%s_cnt%0d", tag, k), cnt6[(k-1)*8 +: 8], e_cnt[k-1]);
            chk($sformatf("%s_hc%0d", tag, k), hc6[(k-1)*8 +: 8], e_hc[k-1]);
            chk($sformatf("%s_m%0d", tag, k), m6[(k-1)*8 +: 8], e_m[k-1]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dups, ncv;
        rst = 1'b1;
        gv6 = 1'b0; gd6 = 8'd0;
        gv16 = 1'b0; gd16 = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy6, 0);
        chk("rst_cntv", cntv6, 0);
        chk("rst_codev", codev6, 0);
        chk("rst_cnt", cnt6, 0);
        chk("rst_hc", hc6, 0);
        chk("rst_m", m6, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // skewed histogram
        foreach (e_cnt[i]) e_cnt[i] = 0;
        e_cnt = '{4, 2, 1, 1, 0, 0};
        e_hc  = '{0, 2, 6, 7, 0, 0};
        e_m   = '{1, 3, 7, 7, 0, 0};
        send6(1); send6(1); send6(1); send6(1);
        send6(2); send6(2); send6(3); send6(4);
        close6("t1");
        chk6("t1");

        // flat histogram
        e_cnt = '{1, 1, 1, 1, 1, 1};
        e_hc  = '{2, 3, 0, 1, 2, 3};
        e_m   = '{7, 7, 7, 7, 3, 3};
        for (int v = 1; v <= 6; v++) send6(v);
        close6("t2");
        chk6("t2");

        // single live symbol among ignored values
        e_cnt = '{0, 0, 5, 0, 0, 0};
        e_hc  = '{0, 0, 0, 0, 0, 0};
        e_m   = '{0, 0, 1, 0, 0, 0};
        send6(3); send6(0); send6(3); send6(7);
        send6(3); send6(200); send6(3); send6(3);
        close6("t3");
        chk6("t3");

        // counter saturation
        e_cnt = '{255, 1, 0, 0, 0, 0};
        e_hc  = '{0, 1, 0, 0, 0, 0};
        e_m   = '{1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 300; i++) send6(1);
        send6(2);
        close6("t4");
        chk6("t4");

        // samples during busy are dropped
        e_cnt = '{1, 1, 0, 0, 0, 0};
        e_hc  = '{0, 1, 0, 0, 0, 0};
        e_m   = '{1, 1, 0, 0, 0, 0};
        send6(1); send6(2);
        @(negedge clk);
        gv6 = 1'b0;
        wait_cntv6("t5");
        gv6 = 1'b1; gd6 = 8'd1;
        repeat (2) @(negedge clk);
        gv6 = 1'b0; gd6 = 8'd0;
        wait_codev6("t5");
        repeat (3) @(negedge clk);
        chk6("t5");

        // reset in the middle of MERGE
        for (int v = 1; v <= 6; v++) send6(v);
        @(negedge clk);
        gv6 = 1'b0;
        wait_cntv6("t6");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", busy6, 0);
        chk("t6_cntv", cntv6, 0);
        chk("t6_codev", codev6, 0);
        chk("t6_cnt", cnt6, 0);
        chk("t6_hc", hc6, 0);
        chk("t6_m", m6, 0);
        rst = 1'b0;
        ncv = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (codev6) ncv++;
        end
        chk("t6_no_codev", ncv, 0);

        // fresh frame after reset
        e_cnt = '{4, 2, 1, 1, 0, 0};
        e_hc  = '{0, 2, 6, 7, 0, 0};
        e_m   = '{1, 3, 7, 7, 0, 0};
        send6(1); send6(1); send6(1); send6(1);
        send6(2); send6(2); send6(3); send6(4);
        close6("t7");
        chk6("t7");

        // 16 symbols, uniform
        for (int v = 1; v <= 16; v++) begin
            @(negedge clk);
            gv16 = 1'b1;
            gd16 = 8'(v);
        end
        @(negedge clk);
        gv16 = 1'b0;
        gd16 = 8'd0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (codev16) break;
        end
        chk("t8_codev_seen", codev16, 1);
        for (int k = 0; k < 16; k++)
            chk($sformatf("t8_m%0d", k + 1), m16[k*16 +: 16], 16'h000F);
        dups = 0;
        for (int a = 0; a < 16; a++)
            for (int b = a + 1; b < 16; b++)
                if (hc16[a*16 +: 16] == hc16[b*16 +: 16]) dups++;
        chk("t8_distinct", dups, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
